// File: rtl/adder_arbiter_if.sv
// Request/response bundle for adder_arbiter: two operand requesters and one result consumer.
interface adder_arbiter_if;
  logic       req0_valid;
  logic [5:0] req0_a;
  logic [5:0] req0_b;
  logic       req0_cin;
  logic       req0_ready;
  logic       req1_valid;
  logic [5:0] req1_a;
  logic [5:0] req1_b;
  logic       req1_cin;
  logic       req1_ready;
  logic       resp_valid;
  logic       resp_id;
  logic [5:0] resp_sum;
  logic       resp_carry;
  logic       resp_ready;

  modport master (
    output req0_valid, req0_a, req0_b, req0_cin,
    output req1_valid, req1_a, req1_b, req1_cin,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_sum, resp_carry
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin,
    input  req1_valid, req1_a, req1_b, req1_cin,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_sum, resp_carry
  );
endinterface

// File: rtl/adder_arbiter.sv
// Two-requester round-robin front end sharing one 6-bit ripple-carry adder.
// state | meaning
// IDLE  | arbitrating, granted requester sees ready
// LOAD  | registered operands drive the adder
// DONE  | result held on resp_* until consumer accepts

module ripple_ca_adder (
  input  logic [5:0] a_i,
  input  logic [5:0] b_i,
  input  logic       cin_i,
  output logic [5:0] sum_o,
  output logic       cout_o
);
  logic carry;

  always_comb begin
    carry = cin_i;
    sum_o = '0;
    for (int i = 0; i < 6; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry;
  end
endmodule

module adder_arbiter (
  input  logic            clk,
  input  logic            rst,
  adder_arbiter_if.slave  arb
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic [5:0] a_q, a_d, b_q, b_d;
  logic       cin_q, cin_d, id_q, id_d;
  logic [5:0] sum_q, sum_d;
  logic       carry_q, carry_d, rid_q, rid_d;

  logic       grant;
  logic       idle_ok;
  logic       hs0, hs1;
  logic [5:0] add_sum;
  logic       add_cout;

  ripple_ca_adder u_adder (
    .a_i    (a_q),
    .b_i    (b_q),
    .cin_i  (cin_q),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // On contention the requester that did not win last time is granted.
  always_comb begin
    grant = 1'b0;
    if (arb.req0_valid && arb.req1_valid) grant = ~last_grant_q;
    else if (arb.req1_valid)              grant = 1'b1;
  end

  assign idle_ok        = (state_q == IDLE) && !rst;
  assign arb.req0_ready = idle_ok && arb.req0_valid && !grant;
  assign arb.req1_ready = idle_ok && arb.req1_valid && grant;
  assign hs0            = arb.req0_valid && arb.req0_ready;
  assign hs1            = arb.req1_valid && arb.req1_ready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    cin_d        = cin_q;
    id_d         = id_q;
    sum_d        = sum_q;
    carry_d      = carry_q;
    rid_d        = rid_q;
    case (state_q)
      IDLE: begin
        if (hs0) begin
          a_d = arb.req0_a; b_d = arb.req0_b; cin_d = arb.req0_cin;
          id_d = 1'b0; last_grant_d = 1'b0; state_d = LOAD;
        end else if (hs1) begin
          a_d = arb.req1_a; b_d = arb.req1_b; cin_d = arb.req1_cin;
          id_d = 1'b1; last_grant_d = 1'b1; state_d = LOAD;
        end
      end
      LOAD: begin
        sum_d   = add_sum;
        carry_d = add_cout;
        rid_d   = id_q;
        state_d = DONE;
      end
      DONE: begin
        if (arb.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      cin_q        <= 1'b0;
      id_q         <= 1'b0;
      sum_q        <= '0;
      carry_q      <= 1'b0;
      rid_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cin_q        <= cin_d;
      id_q         <= id_d;
      sum_q        <= sum_d;
      carry_q      <= carry_d;
      rid_q        <= rid_d;
    end
  end

  assign arb.resp_valid = (state_q == DONE);
  assign arb.resp_id    = rid_q;
  assign arb.resp_sum   = sum_q;
  assign arb.resp_carry = carry_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: arbitration order, latency, backpressure, reset, full sweep.
module tb_adder_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  adder_arbiter_if bus ();

  adder_arbiter dut (
    .clk (clk),
    .rst (rst),
    .arb (bus)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return bus.req0_ready;
      1:       return bus.req1_ready;
      default: return bus.resp_valid;
    endcase
  endfunction

  // Bounded wait, sampled 1 ns after a falling edge.
  task automatic wait_for(input int which, input string tag);
    int cnt;
    cnt = 0;
    #1;
    while (!sig(which) && cnt < 16) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    check(tag, int'(sig(which)), 1);
  endtask

  task automatic drive0(input logic v, input logic [5:0] a, input logic [5:0] b, input logic c);
    bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_cin = c;
  endtask

  task automatic drive1(input logic v, input logic [5:0] a, input logic [5:0] b, input logic c);
    bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_cin = c;
  endtask

  initial begin
    rst = 1'b1;
    drive0(1'b1, 6'd0, 6'd0, 1'b0);
    drive1(1'b1, 6'd0, 6'd0, 1'b0);
    bus.resp_ready = 1'b1;

    // Reset: readies held low even with both requesters valid.
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready0", int'(bus.req0_ready), 0);
    check("rst_ready1", int'(bus.req1_ready), 0);
    check("rst_resp_valid", int'(bus.resp_valid), 0);
    check("rst_resp_id", int'(bus.resp_id), 0);
    check("rst_resp_sum", int'(bus.resp_sum), 0);
    check("rst_resp_carry", int'(bus.resp_carry), 0);
    drive0(1'b0, 6'd0, 6'd0, 1'b0);
    drive1(1'b0, 6'd0, 6'd0, 1'b0);
    rst = 1'b0;

    // Single req0: 63+1+0 wraps to 0 with carry.
    @(negedge clk);
    drive0(1'b1, 6'd63, 6'd1, 1'b0);
    #1;
    check("t31_ready0", int'(bus.req0_ready), 1);
    check("t31_ready1", int'(bus.req1_ready), 0);
    @(negedge clk);
    drive0(1'b0, 6'd0, 6'd0, 1'b0);
    #1;
    check("t31_load_valid", int'(bus.resp_valid), 0);
    check("t31_load_ready0", int'(bus.req0_ready), 0);
    @(negedge clk);
    #1;
    check("t31_valid", int'(bus.resp_valid), 1);
    check("t31_id", int'(bus.resp_id), 0);
    check("t31_sum", int'(bus.resp_sum), 0);
    check("t31_carry", int'(bus.resp_carry), 1);
    @(negedge clk);
    #1;
    check("t31_retire", int'(bus.resp_valid), 0);

    // Contention right after reset: req0 first, then req1.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive0(1'b1, 6'd10, 6'd5, 1'b1);
    drive1(1'b1, 6'd20, 6'd30, 1'b0);
    #1;
    check("t32_ready0", int'(bus.req0_ready), 1);
    check("t32_ready1", int'(bus.req1_ready), 0);
    @(negedge clk);
    drive0(1'b0, 6'd0, 6'd0, 1'b0);
    #1;
    check("t32_load_ready1", int'(bus.req1_ready), 0);
    @(negedge clk);
    #1;
    check("t32_a_valid", int'(bus.resp_valid), 1);
    check("t32_a_id", int'(bus.resp_id), 0);
    check("t32_a_sum", int'(bus.resp_sum), 16);
    check("t32_a_carry", int'(bus.resp_carry), 0);
    @(negedge clk);
    #1;
    check("t32_gap_ready1", int'(bus.req1_ready), 1);
    @(negedge clk);
    drive1(1'b0, 6'd0, 6'd0, 1'b0);
    @(negedge clk);
    #1;
    check("t32_b_valid", int'(bus.resp_valid), 1);
    check("t32_b_id", int'(bus.resp_id), 1);
    check("t32_b_sum", int'(bus.resp_sum), 50);
    check("t32_b_carry", int'(bus.resp_carry), 0);
    @(negedge clk);

    // Continuous contention alternates 0,1,0,1,0,1.
    drive0(1'b1, 6'd1, 6'd2, 1'b0);
    drive1(1'b1, 6'd4, 6'd5, 1'b1);
    for (int g = 0; g < 6; g++) begin
      wait_for(2, "t33_wait");
      check("t33_id", int'(bus.resp_id), g % 2);
      check("t33_sum", int'(bus.resp_sum), (g % 2 == 1) ? 10 : 3);
      @(negedge clk);
    end
    drive0(1'b0, 6'd0, 6'd0, 1'b0);
    drive1(1'b0, 6'd0, 6'd0, 1'b0);
    @(negedge clk);

    // Backpressure: response held for 5 cycles, no readies meanwhile.
    bus.resp_ready = 1'b0;
    drive0(1'b1, 6'd7, 6'd8, 1'b0);
    wait_for(0, "t34_ready0");
    @(negedge clk);
    drive0(1'b0, 6'd0, 6'd0, 1'b0);
    drive1(1'b1, 6'd1, 6'd1, 1'b0);
    wait_for(2, "t34_wait");
    for (int k = 0; k < 5; k++) begin
      check("t34_hold_valid", int'(bus.resp_valid), 1);
      check("t34_hold_sum", int'(bus.resp_sum), 15);
      check("t34_hold_ready0", int'(bus.req0_ready), 0);
      check("t34_hold_ready1", int'(bus.req1_ready), 0);
      @(negedge clk);
      #1;
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("t34_retired", int'(bus.resp_valid), 0);
    check("t34_next_ready1", int'(bus.req1_ready), 1);
    drive1(1'b0, 6'd0, 6'd0, 1'b0);
    @(negedge clk);

    // Reset during LOAD drops the operation.
    drive1(1'b1, 6'd33, 6'd33, 1'b1);
    wait_for(1, "t35_ready1");
    @(negedge clk);
    drive1(1'b0, 6'd0, 6'd0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    drive0(1'b1, 6'd2, 6'd2, 1'b0);
    #1;
    check("t35_rst_ready0", int'(bus.req0_ready), 0);
    check("t35_rst_valid", int'(bus.resp_valid), 0);
    drive0(1'b0, 6'd0, 6'd0, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("t35_no_resp", int'(bus.resp_valid), 0);
      check("t35_sum_zero", int'(bus.resp_sum), 0);
    end
    drive0(1'b1, 6'd1, 6'd1, 1'b0);
    drive1(1'b1, 6'd1, 6'd1, 1'b0);
    #1;
    check("t35_cont_ready0", int'(bus.req0_ready), 1);
    check("t35_cont_ready1", int'(bus.req1_ready), 0);
    drive0(1'b0, 6'd0, 6'd0, 1'b0);
    drive1(1'b0, 6'd0, 6'd0, 1'b0);
    @(negedge clk);

    // Exhaustive arithmetic sweep through req1.
    for (int a = 0; a < 64; a++) begin
      for (int b = 0; b < 64; b++) begin
        for (int c = 0; c < 2; c++) begin
          drive1(1'b1, 6'(a), 6'(b), 1'(c));
          wait_for(1, "t36_ready1");
          @(negedge clk);
          drive1(1'b0, 6'd0, 6'd0, 1'b0);
          wait_for(2, "t36_wait");
          check("t36_result", int'({bus.resp_carry, bus.resp_sum}), a + b + c);
          @(negedge clk);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
